// File: rtl/gpio_input_filter_bank.sv
// rtl/gpio_input_filter_bank.sv - per-channel GPIO synchronizer, glitch filter, edge detect and sticky irq
module gpio_input_filter_bank #(
    parameter int NrGpios      = 32,
    parameter int NrSyncStages = 2,
    parameter int CntWidth     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NrGpios-1:0]   en_i,
    input  logic [NrGpios-1:0]   serial_i,
    input  logic [NrGpios-1:0]   debounce_en_i,
    input  logic [CntWidth-1:0]  debounce_thresh_i,
    input  logic [NrGpios-1:0]   irq_en_i,
    input  logic [2*NrGpios-1:0] irq_mode_i,
    input  logic [NrGpios-1:0]   irq_clr_i,
    output logic [NrGpios-1:0]   serial_o,
    output logic [NrGpios-1:0]   r_edge_o,
    output logic [NrGpios-1:0]   f_edge_o,
    output logic [NrGpios-1:0]   irq_status_o,
    output logic                 irq_o
);

    for (genvar i = 0; i < NrGpios; i++) begin : g_ch
        logic [NrSyncStages-1:0] sync_q;
        logic [CntWidth-1:0]     cnt_q;
        logic [CntWidth-1:0]     cnt_d;
        logic                    s;
        logic                    f_q;
        logic                    f_d;
        logic                    r_edge_q;
        logic                    f_edge_q;
        logic                    status_q;
        logic                    irq_evt;

        assign s = sync_q[NrSyncStages-1];

        // Synchronizer chain; frozen while the channel is disabled so the
        // last seen value survives until re-enable.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= '0;
            end else if (en_i[i]) begin
                sync_q <= {sync_q[NrSyncStages-2:0], serial_i[i]};
            end
        end

        // Glitch filter: accept s once it has differed from f for T+1 cycles.
        // The >= compare lets a lowered threshold take effect mid-count.
        always_comb begin
            f_d   = f_q;
            cnt_d = '0;
            if (en_i[i] && (s != f_q)) begin
                if (!debounce_en_i[i] || (cnt_q >= debounce_thresh_i)) begin
                    f_d = s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Filtered value, counter and edge pulses, all updated together so
        // an edge pulse coincides with the first cycle of the new value.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                f_q      <= 1'b0;
                cnt_q    <= '0;
                r_edge_q <= 1'b0;
                f_edge_q <= 1'b0;
            end else begin
                f_q      <= f_d;
                cnt_q    <= cnt_d;
                r_edge_q <= f_d & ~f_q;
                f_edge_q <= ~f_d & f_q;
            end
        end

        // Interrupt event selected by the 2-bit mode of this channel.
        always_comb begin
            irq_evt = 1'b0;
            unique case (irq_mode_i[2*i+:2])
                2'b00:   irq_evt = r_edge_q;
                2'b01:   irq_evt = f_edge_q;
                2'b10:   irq_evt = r_edge_q | f_edge_q;
                default: irq_evt = f_q;
            endcase
        end

        // Sticky status; a new event outranks a simultaneous clear.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                status_q <= 1'b0;
            end else begin
                status_q <= (irq_evt & irq_en_i[i]) | (status_q & ~irq_clr_i[i]);
            end
        end

        assign serial_o[i]     = f_q;
        assign r_edge_o[i]     = r_edge_q;
        assign f_edge_o[i]     = f_edge_q;
        assign irq_status_o[i] = status_q;
    end

    assign irq_o = |irq_status_o;

endmodule

// File: tb/tb_gpio_input_filter_bank.sv
// tb/tb_gpio_input_filter_bank.sv - directed bench with edge-event scoreboard for gpio_input_filter_bank
module tb_gpio_input_filter_bank;

    localparam int N  = 32;
    localparam int CW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  en_i;
    logic [N-1:0]  serial_i;
    logic [N-1:0]  debounce_en_i;
    logic [CW-1:0] debounce_thresh_i;
    logic [N-1:0]  irq_en_i;
    logic [2*N-1:0] irq_mode_i;
    logic [N-1:0]  irq_clr_i;
    logic [N-1:0]  serial_o;
    logic [N-1:0]  r_edge_o;
    logic [N-1:0]  f_edge_o;
    logic [N-1:0]  irq_status_o;
    logic          irq_o;

    gpio_input_filter_bank #(.NrGpios(N), .NrSyncStages(2), .CntWidth(CW)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .en_i              (en_i),
        .serial_i          (serial_i),
        .debounce_en_i     (debounce_en_i),
        .debounce_thresh_i (debounce_thresh_i),
        .irq_en_i          (irq_en_i),
        .irq_mode_i        (irq_mode_i),
        .irq_clr_i         (irq_clr_i),
        .serial_o          (serial_o),
        .r_edge_o          (r_edge_o),
        .f_edge_o          (f_edge_o),
        .irq_status_o      (irq_status_o),
        .irq_o             (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  ch;
        logic        rise;
    } edge_t;

    edge_t exp_q[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input int ch, input logic rise);
        edge_t e;
        e.cyc  = c;
        e.ch   = ch[7:0];
        e.rise = rise;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Every edge pulse the DUT emits must match the next expected event.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            for (int ch = 0; ch < N; ch++) begin
                if (r_edge_o[ch] || f_edge_o[ch]) begin
                    edge_t got;
                    edge_t want;
                    got.cyc  = cyc;
                    got.ch   = ch[7:0];
                    got.rise = r_edge_o[ch];
                    total++;
                    assert (exp_q.size() > 0) else begin
                        bad++;
                        $error("FAIL edge_unexpected observed=cyc%0d/ch%0d/rise%0d expected=none",
                               cyc, ch, r_edge_o[ch]);
                    end
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        chk("edge_event", {31'd0, got}, {31'd0, want});
                    end
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        en_i = '1;
        serial_i = '0;
        debounce_en_i = '0;
        debounce_thresh_i = '0;
        irq_en_i = '0;
        irq_mode_i = '0;
        irq_clr_i = '0;

        // Reset state
        step(3);
        chk("rst_serial", serial_o, 0);
        chk("rst_redge", r_edge_o, 0);
        chk("rst_fedge", f_edge_o, 0);
        chk("rst_status", irq_status_o, 0);
        chk("rst_irq", irq_o, 0);
        rst_ni = 1'b1;
        step(3);

        // Unfiltered: 3-cycle latency, single-cycle pulses
        serial_i[0] = 1'b1;
        push(cyc + 3, 0, 1'b1);
        step(2);
        chk("unf_before", serial_o[0], 0);
        step(1);
        chk("unf_serial", serial_o[0], 1);
        chk("unf_redge", r_edge_o[0], 1);
        step(1);
        chk("unf_pulse_width", r_edge_o[0], 0);
        step(4);
        serial_i[0] = 1'b0;
        push(cyc + 3, 0, 1'b0);
        step(3);
        chk("unf_fedge", f_edge_o[0], 1);
        step(4);

        // Filter T=4: a 4-cycle glitch is dropped
        debounce_en_i[0] = 1'b1;
        debounce_thresh_i = 8'd4;
        step(1);
        serial_i[0] = 1'b1;
        step(4);
        serial_i[0] = 1'b0;
        step(12);
        chk("glitch_dropped", serial_o[0], 0);

        // Filter T=4: a 5-cycle high passes after NrSyncStages+T+1 = 7 cycles
        serial_i[0] = 1'b1;
        push(cyc + 7, 0, 1'b1);
        step(5);
        serial_i[0] = 1'b0;
        push(cyc + 7, 0, 1'b0);
        step(1);
        chk("filt_before", serial_o[0], 0);
        step(1);
        chk("filt_rise", serial_o[0], 1);
        step(10);
        chk("filt_fall", serial_o[0], 0);

        // Filter enabled with T=0 behaves like the unfiltered path
        debounce_thresh_i = 8'd0;
        step(1);
        serial_i[0] = 1'b1;
        push(cyc + 3, 0, 1'b1);
        step(6);
        serial_i[0] = 1'b0;
        push(cyc + 3, 0, 1'b0);
        step(6);
        debounce_en_i[0] = 1'b0;

        // Both-edge interrupt on ch1, clear, then set-vs-clear collision
        irq_mode_i[3:2] = 2'b10;
        irq_en_i[1] = 1'b1;
        step(1);
        serial_i[1] = 1'b1;
        push(cyc + 3, 1, 1'b1);
        step(3);
        chk("irq_not_yet", irq_status_o[1], 0);
        step(1);
        chk("irq_set_rise", irq_status_o[1], 1);
        chk("irq_o_set", irq_o, 1);
        irq_clr_i[1] = 1'b1;
        step(1);
        irq_clr_i[1] = 1'b0;
        chk("irq_cleared", irq_status_o[1], 0);
        chk("irq_o_clear", irq_o, 0);
        serial_i[1] = 1'b0;
        push(cyc + 3, 1, 1'b0);
        step(3);
        irq_clr_i[1] = 1'b1;
        step(1);
        irq_clr_i[1] = 1'b0;
        chk("set_wins_clear", irq_status_o[1], 1);
        irq_clr_i[1] = 1'b1;
        step(1);
        irq_clr_i[1] = 1'b0;
        chk("clear_after_fall", irq_status_o[1], 0);

        // Level-high mode: clear cannot win while the input stays high
        irq_mode_i[3:2] = 2'b11;
        step(1);
        serial_i[1] = 1'b1;
        push(cyc + 3, 1, 1'b1);
        step(4);
        chk("level_set", irq_status_o[1], 1);
        irq_clr_i[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("level_hold", irq_status_o[1], 1);
        end
        serial_i[1] = 1'b0;
        push(cyc + 3, 1, 1'b0);
        step(4);
        chk("level_cleared", irq_status_o[1], 0);
        irq_clr_i[1] = 1'b0;
        irq_mode_i[3:2] = 2'b00;
        irq_en_i[1] = 1'b0;
        step(2);

        // Disabled channel ignores its input; edge 3 cycles after re-enable
        en_i[3] = 1'b0;
        step(1);
        serial_i[3] = 1'b1;
        step(20);
        chk("disabled_hold", serial_o[3], 0);
        en_i[3] = 1'b1;
        push(cyc + 3, 3, 1'b1);
        step(2);
        chk("reen_not_yet", serial_o[3], 0);
        step(1);
        chk("reen_redge", r_edge_o[3], 1);
        step(3);

        // Asynchronous reset mid-debounce with every status bit set
        irq_mode_i = '1;
        irq_en_i = '1;
        serial_i = '1;
        for (int ch = 0; ch < N; ch++) begin
            if (ch != 3) push(cyc + 3, ch, 1'b1);
        end
        step(5);
        chk("all_status", irq_status_o, 32'hFFFF_FFFF);
        debounce_en_i = '1;
        debounce_thresh_i = 8'd10;
        serial_i = '0;
        step(4);
        chk("mid_debounce", serial_o, 32'hFFFF_FFFF);
        rst_ni = 1'b0;
        #1;
        chk("async_serial", serial_o, 0);
        chk("async_status", irq_status_o, 0);
        chk("async_irq", irq_o, 0);
        step(3);
        rst_ni = 1'b1;
        step(1);
        chk("post_rst_serial", serial_o, 0);
        chk("post_rst_edges", r_edge_o | f_edge_o, 0);
        step(10);
        chk("post_rst_status", irq_status_o, 0);
        chk("pending_edges", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
